// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with almost-full/empty thresholds and a
// registered last-operation status. Macro FIFO_SIMUL_RW_EN enables simultaneous read+write.
`default_nettype none

module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_TH   = 7,
    parameter int AEMPTY_TH  = 1,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [CW-1:0]         data_count,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_INIT   = 3'b000,
        S_WRITE  = 3'b001,
        S_READ   = 3'b010,
        S_RDWR   = 3'b011,
        S_NO_OP  = 3'b100,
        S_WR_ERR = 3'b101,
        S_RD_ERR = 3'b110
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           head_q, head_d;
    logic [AW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    wr_err_q, wr_err_d;
    logic                    rd_ack_q, rd_ack_d;
    logic                    rd_err_q, rd_err_d;
    logic                    do_wr, do_rd;
    logic                    is_full, is_empty;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    always_comb begin
        state_d  = S_NO_OP;
        do_wr    = 1'b0;
        do_rd    = 1'b0;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;
        case ({wr_en, rd_en})
            2'b10: begin
                if (is_full) begin
                    state_d  = S_WR_ERR;
                    wr_err_d = 1'b1;
                end else begin
                    state_d  = S_WRITE;
                    do_wr    = 1'b1;
                    wr_ack_d = 1'b1;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    state_d  = S_RD_ERR;
                    rd_err_d = 1'b1;
                end else begin
                    state_d  = S_READ;
                    do_rd    = 1'b1;
                    rd_ack_d = 1'b1;
                end
            end
            2'b11: begin
`ifdef FIFO_SIMUL_RW_EN
                // Empty and full are exclusive since DEPTH >= 2; the blocked side errors.
                if (is_empty) begin
                    state_d  = S_WRITE;
                    do_wr    = 1'b1;
                    wr_ack_d = 1'b1;
                    rd_err_d = 1'b1;
                end else if (is_full) begin
                    state_d  = S_READ;
                    do_rd    = 1'b1;
                    rd_ack_d = 1'b1;
                    wr_err_d = 1'b1;
                end else begin
                    state_d  = S_RDWR;
                    do_wr    = 1'b1;
                    do_rd    = 1'b1;
                    wr_ack_d = 1'b1;
                    rd_ack_d = 1'b1;
                end
`else
                state_d = S_NO_OP;
`endif
            end
            default: state_d = S_NO_OP;
        endcase
    end

    always_comb begin
        head_d  = do_rd ? head_q + AW'(1) : head_q;
        tail_d  = do_wr ? tail_q + AW'(1) : tail_q;
        count_d = count_q + CW'(do_wr) - CW'(do_rd);
        dout_d  = do_rd ? mem_q[head_q] : dout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage is not reset; contents are only observable after a write.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[tail_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= CW'(AFULL_TH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign rd_ack       = rd_ack_q;
    assign rd_err       = rd_err_q;
    assign data_count   = count_q;
    assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed and randomized checks of fifo_param against a queue-based model.
`default_nettype none

module tb_fifo_param;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] din;
    logic [31:0] dout;
    logic        full, empty, almost_full, almost_empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;
    logic [3:0]  data_count;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue contents plus last-operation outputs.
    logic [31:0] m_q[$];
    logic [2:0]  m_state;
    logic [31:0] m_dout;
    logic        m_wa, m_we, m_ra, m_re;

    fifo_param #(.DATA_WIDTH(32), .DEPTH(8), .AFULL_TH(7), .AEMPTY_TH(1)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_ack(rd_ack), .rd_err(rd_err), .data_count(data_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_state = 3'b000;
        m_dout  = '0;
        {m_wa, m_we, m_ra, m_re} = 4'b0000;
    endtask

    // Drive one request, let one rising edge pass, advance the model, sample 1ns later.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        int n;
        wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        n = m_q.size();
        {m_wa, m_we, m_ra, m_re} = 4'b0000;
        if (w && !r) begin
            if (n == 8) begin m_state = 3'b101; m_we = 1'b1; end
            else begin m_q.push_back(d); m_state = 3'b001; m_wa = 1'b1; end
        end else if (r && !w) begin
            if (n == 0) begin m_state = 3'b110; m_re = 1'b1; end
            else begin m_dout = m_q.pop_front(); m_state = 3'b010; m_ra = 1'b1; end
        end else if (!w && !r) begin
            m_state = 3'b100;
        end else begin
`ifdef FIFO_SIMUL_RW_EN
            if (n == 0) begin
                m_q.push_back(d); m_state = 3'b001; m_wa = 1'b1; m_re = 1'b1;
            end else if (n == 8) begin
                m_dout = m_q.pop_front(); m_state = 3'b010; m_ra = 1'b1; m_we = 1'b1;
            end else begin
                m_dout = m_q.pop_front(); m_q.push_back(d);
                m_state = 3'b011; m_wa = 1'b1; m_ra = 1'b1;
            end
`else
            m_state = 3'b100;
`endif
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        #1;
        n_tests++; if (state !== 3'b000) begin n_fail++; $display("FAIL reset_state got %b exp 000", state); end
        n_tests++; if (data_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", data_count); end
        n_tests++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags got %b exp 1010", {empty, full, almost_empty, almost_full}); end
        n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", dout); end
        n_tests++; if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_acks got %b exp 0000", {wr_ack, wr_err, rd_ack, rd_err}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 32'h0);
        n_tests++; if (state !== 3'b100) begin n_fail++; $display("FAIL init_to_noop got %b exp 100", state); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h11 * (i + 1));
            n_tests++; if (data_count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, data_count, i + 1); end
            n_tests++; if ({wr_ack, state} !== 4'b1001) begin n_fail++; $display("FAIL fill_ack_state i=%0d got %b exp 1001", i, {wr_ack, state}); end
            n_tests++; if ({full, almost_full} !== {i == 7, i >= 6}) begin n_fail++; $display("FAIL fill_fullflags i=%0d got %b exp %b", i, {full, almost_full}, {i == 7, i >= 6}); end
        end
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        n_tests++; if ({wr_err, wr_ack, state, data_count} !== {2'b10, 3'b101, 4'd8}) begin n_fail++; $display("FAIL fill_overflow got err=%b ack=%b st=%b cnt=%0d exp 1 0 101 8", wr_err, wr_ack, state, data_count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'h0);
            n_tests++; if (dout !== 32'h11 * (i + 1)) begin n_fail++; $display("FAIL drain_dout i=%0d got %h exp %h", i, dout, 32'h11 * (i + 1)); end
            n_tests++; if ({rd_ack, state, data_count} !== {1'b1, 3'b010, 4'(7 - i)}) begin n_fail++; $display("FAIL drain_status i=%0d got ack=%b st=%b cnt=%0d", i, rd_ack, state, data_count); end
        end
        n_tests++; if ({empty, almost_empty} !== 2'b11) begin n_fail++; $display("FAIL drain_empty got %b exp 11", {empty, almost_empty}); end
        step(1'b0, 1'b1, 32'h0);
        n_tests++; if ({rd_err, rd_ack, state, dout} !== {2'b10, 3'b110, 32'h88}) begin n_fail++; $display("FAIL drain_underflow got err=%b ack=%b st=%b dout=%h exp 1 0 110 88", rd_err, rd_ack, state, dout); end
    endtask

    task automatic test_wrap();
        int plan[4] = '{5, 5, 6, 6};
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < plan[p]; i++) begin
                step(p[0] == 1'b0, p[0] == 1'b1, $urandom);
                if (p[0]) begin
                    n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL wrap_dout p=%0d i=%0d got %h exp %h", p, i, dout, m_dout); end
                end
            end
        end
        n_tests++; if ({data_count, empty} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL wrap_count got %0d empty=%b exp 0 1", data_count, empty); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, $urandom);
`ifdef FIFO_SIMUL_RW_EN
            n_tests++; if ({state, data_count, wr_ack, rd_ack} !== {3'b011, 4'd3, 2'b11}) begin n_fail++; $display("FAIL simul_rdwr i=%0d got st=%b cnt=%0d acks=%b", i, state, data_count, {wr_ack, rd_ack}); end
            n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL simul_dout i=%0d got %h exp %h", i, dout, m_dout); end
`else
            n_tests++; if ({state, data_count, wr_ack, wr_err, rd_ack, rd_err} !== {3'b100, 4'd3, 4'b0000}) begin n_fail++; $display("FAIL simul_noop i=%0d got st=%b cnt=%0d flags=%b", i, state, data_count, {wr_ack, wr_err, rd_ack, rd_err}); end
`endif
        end
        while (m_q.size() != 0) step(1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b1, 32'hCAFE_0001);
`ifdef FIFO_SIMUL_RW_EN
        n_tests++; if ({state, rd_err, wr_ack, data_count} !== {3'b001, 2'b11, 4'd1}) begin n_fail++; $display("FAIL simul_empty got st=%b rd_err=%b wr_ack=%b cnt=%0d exp 001 1 1 1", state, rd_err, wr_ack, data_count); end
`else
        n_tests++; if ({state, rd_err, wr_ack, data_count} !== {3'b100, 2'b00, 4'd0}) begin n_fail++; $display("FAIL simul_empty got st=%b rd_err=%b wr_ack=%b cnt=%0d exp 100 0 0 0", state, rd_err, wr_ack, data_count); end
`endif
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 300; i++) begin
            // Bias towards writes early and reads late so both full and empty are visited.
            step($urandom_range(99) < (i < 150 ? 65 : 35), $urandom_range(99) < (i < 150 ? 35 : 65), $urandom);
            n = m_q.size();
            n_tests++;
            if ({state, data_count, dout, wr_ack, wr_err, rd_ack, rd_err, full, empty, almost_full, almost_empty}
                !== {m_state, 4'(n), m_dout, m_wa, m_we, m_ra, m_re, n == 8, n == 0, n >= 7, n <= 1}) begin
                n_fail++;
                $display("FAIL random i=%0d got st=%b cnt=%0d dout=%h fl=%b exp st=%b cnt=%0d dout=%h fl=%b",
                         i, state, data_count, dout, {wr_ack, wr_err, rd_ack, rd_err, full, empty, almost_full, almost_empty},
                         m_state, n, m_dout, {m_wa, m_we, m_ra, m_re, n == 8, n == 0, n >= 7, n <= 1});
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom);
        step(1'b0, 1'b1, 32'h0);
        wr_en = 1'b1; din = 32'h5555_AAAA;
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if ({state, data_count, dout} !== {3'b000, 4'd0, 32'h0}) begin n_fail++; $display("FAIL midreset_core got st=%b cnt=%0d dout=%h exp 000 0 0", state, data_count, dout); end
        n_tests++; if ({wr_ack, wr_err, rd_ack, rd_err, full, empty, almost_full, almost_empty} !== 8'b0000_0101) begin n_fail++; $display("FAIL midreset_flags got %b exp 00000101", {wr_ack, wr_err, rd_ack, rd_err, full, empty, almost_full, almost_empty}); end
        @(posedge clk); #1;
        n_tests++; if ({state, data_count} !== {3'b000, 4'd0}) begin n_fail++; $display("FAIL midreset_hold got st=%b cnt=%0d exp 000 0", state, data_count); end
        wr_en = 1'b0;
        reset_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 32'h0);
        n_tests++; if ({state, rd_err, dout} !== {3'b110, 1'b1, 32'h0}) begin n_fail++; $display("FAIL midreset_after got st=%b rd_err=%b dout=%h exp 110 1 0", state, rd_err, dout); end
    endtask

    initial begin
        reset_n = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
